slow_line_mem: RTL and testbench



---
 rtl/slow_line_mem.sv | 121 ++++++++++++
 tb/tb_slow_line_mem.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_line_mem.sv
// Line-granular slow backing memory: one SWAP_IN/SWAP_OUT request at a time,
// completed after LATENCY cycles with a one-cycle registered gnt pulse.
module slow_line_mem #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 10,
    parameter int LATENCY       = 50,
    localparam int LINE_SIZE    = 1 << LINE_ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                gnt,
    input  logic [ADDR_LEN-1:0] addr,
    input  logic                rd_req,
    output logic [31:0]         rd_line [LINE_SIZE],
    input  logic                wr_req,
    input  logic [31:0]         wr_line [LINE_SIZE]
);

    localparam int WORDS = 1 << (ADDR_LEN + LINE_ADDR_LEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef logic [31:0] mem_t [WORDS];

    // Word index {line, offset} equals the power-up value of that word.
    function automatic mem_t init_mem();
        mem_t m;
        for (int j = 0; j < WORDS; j++) begin
            m[j] = 32'(j);
        end
        return m;
    endfunction

    mem_t mem = init_mem();

    state_t              state, state_nx;
    logic [7:0]          cnt, cnt_nx;
    logic                op_wr;
    logic [ADDR_LEN-1:0] addr_q;
    logic [31:0]         wr_buf [LINE_SIZE];
    logic                req_held;
    logic                accept;
    logic                load_rd;
    logic                commit;

    // The request that was accepted must stay high; otherwise it is aborted.
    assign req_held = op_wr ? wr_req : rd_req;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        load_rd  = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req || wr_req) begin
                    accept   = 1'b1;
                    cnt_nx   = 8'(LATENCY - 2);
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (!req_held) begin
                    state_nx = IDLE;
                end else if (cnt == 8'd0) begin
                    load_rd  = !op_wr;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            DONE: begin
                commit   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            gnt    <= 1'b0;
            op_wr  <= 1'b0;
            addr_q <= '0;
            for (int i = 0; i < LINE_SIZE; i++) begin
                rd_line[i] <= 32'd0;
                wr_buf[i]  <= 32'd0;
            end
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            gnt   <= commit;
            if (accept) begin
                op_wr  <= wr_req;
                addr_q <= addr;
                if (wr_req) begin
                    for (int i = 0; i < LINE_SIZE; i++) begin
                        wr_buf[i] <= wr_line[i];
                    end
                end
            end
            if (load_rd) begin
                for (int i = 0; i < LINE_SIZE; i++) begin
                    rd_line[i] <= mem[{addr_q, LINE_ADDR_LEN'(i)}];
                end
            end
        end
    end

    // Storage survives reset; a write lands only on the DONE edge.
    always_ff @(posedge clk) begin
        if (commit && op_wr) begin
            for (int i = 0; i < LINE_SIZE; i++) begin
                mem[{addr_q, LINE_ADDR_LEN'(i)}] <= wr_buf[i];
            end
        end
    end

endmodule

// File: tb/tb_slow_line_mem.sv
// Directed bench for slow_line_mem at LATENCY=4: reads, writes, back-to-back,
// abort, latched address, reset mid-write and simultaneous requests.
module tb_slow_line_mem;

  localparam int LAT = 4;
  localparam int LAL = 3;
  localparam int AL  = 10;
  localparam int LS  = 1 << LAL;

  // clock / reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          gnt;
  logic [AL-1:0] addr = '0;
  logic          rd_req = 1'b0;
  logic          wr_req = 1'b0;
  logic [31:0]   rd_line [LS];
  logic [31:0]   wr_line [LS];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  slow_line_mem #(
    .LINE_ADDR_LEN(LAL),
    .ADDR_LEN(AL),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .gnt(gnt),
    .addr(addr),
    .rd_req(rd_req),
    .rd_line(rd_line),
    .wr_req(wr_req),
    .wr_line(wr_line)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First edge waited on is numbered 'start'; returns the cycle gnt was seen, or -1.
  task automatic wait_gnt(input int start, output int cyc);
    bit found;
    found = 0;
    cyc = -1;
    for (int k = start; k < start + 20; k++) begin
      if (!found) begin
        step();
        if (gnt === 1'b1) begin
          cyc = k;
          found = 1;
        end
      end
    end
  endtask

  task automatic read_line(input logic [AL-1:0] a, output int cyc);
    rd_req = 1'b1;
    addr = a;
    wait_gnt(0, cyc);
    rd_req = 1'b0;
  endtask

  task automatic write_line(input logic [AL-1:0] a, input logic [31:0] base, output int cyc);
    wr_req = 1'b1;
    addr = a;
    for (int i = 0; i < LS; i++) wr_line[i] = base + 32'(i);
    wait_gnt(0, cyc);
    wr_req = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    #2;
    tests++;
    if (gnt !== 1'b0) begin
      fails++;
      $display("FAIL reset_gnt: got %b want 0", gnt);
    end
    for (int i = 0; i < LS; i++) begin
      tests++;
      if (rd_line[i] !== 32'd0) begin
        fails++;
        $display("FAIL reset_rd_line[%0d]: got %0h want 0", i, rd_line[i]);
      end
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_read();
    int cyc;
    read_line(10'd5, cyc);
    tests++;
    if (cyc !== LAT) begin
      fails++;
      $display("FAIL read5_latency: got %0d want %0d", cyc, LAT);
    end
    for (int i = 0; i < LS; i++) begin
      tests++;
      if (rd_line[i] !== 32'(40 + i)) begin
        fails++;
        $display("FAIL read5_word[%0d]: got %0d want %0d", i, rd_line[i], 40 + i);
      end
    end
    step();
    tests++;
    if (gnt !== 1'b0) begin
      fails++;
      $display("FAIL read5_gnt_pulse: got %b want 0 one cycle after gnt", gnt);
    end
    read_line(10'd1023, cyc);
    tests++;
    if (cyc !== LAT) begin
      fails++;
      $display("FAIL read1023_latency: got %0d want %0d", cyc, LAT);
    end
    for (int i = 0; i < LS; i++) begin
      tests++;
      if (rd_line[i] !== 32'(8184 + i)) begin
        fails++;
        $display("FAIL read1023_word[%0d]: got %0d want %0d", i, rd_line[i], 8184 + i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    write_line(10'd3, 32'hA0, cyc);
    tests++;
    if (cyc !== LAT) begin
      fails++;
      $display("FAIL wr3_latency: got %0d want %0d", cyc, LAT);
    end
    // read issued during the gnt cycle; accepted at the next edge
    read_line(10'd3, cyc);
    tests++;
    if (cyc !== LAT) begin
      fails++;
      $display("FAIL rd3_after_wr_latency: got %0d want %0d", cyc, LAT);
    end
    for (int i = 0; i < LS; i++) begin
      tests++;
      if (rd_line[i] !== 32'hA0 + 32'(i)) begin
        fails++;
        $display("FAIL rd3_after_wr_word[%0d]: got %0h want %0h", i, rd_line[i], 32'hA0 + i);
      end
    end
  endtask

  task automatic test_abort();
    int seen;
    int cyc;
    rd_req = 1'b1;
    addr = 10'd7;
    step();
    step();
    step();
    rd_req = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (gnt === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL abort_no_gnt: got %0d gnt pulses want 0", seen);
    end
    for (int i = 0; i < LS; i++) begin
      tests++;
      if (rd_line[i] !== 32'hA0 + 32'(i)) begin
        fails++;
        $display("FAIL abort_rd_line_kept[%0d]: got %0h want %0h", i, rd_line[i], 32'hA0 + i);
      end
    end
    read_line(10'd1, cyc);
    tests++;
    if (cyc !== LAT) begin
      fails++;
      $display("FAIL abort_then_read1_latency: got %0d want %0d", cyc, LAT);
    end
    for (int i = 0; i < LS; i++) begin
      tests++;
      if (rd_line[i] !== 32'(8 + i)) begin
        fails++;
        $display("FAIL abort_then_read1_word[%0d]: got %0d want %0d", i, rd_line[i], 8 + i);
      end
    end
  endtask

  task automatic test_addr_change();
    int cyc;
    step();
    rd_req = 1'b1;
    addr = 10'd2;
    step();
    step();
    addr = 10'd6;
    wait_gnt(2, cyc);
    rd_req = 1'b0;
    tests++;
    if (cyc !== LAT) begin
      fails++;
      $display("FAIL addr_change_latency: got %0d want %0d", cyc, LAT);
    end
    for (int i = 0; i < LS; i++) begin
      tests++;
      if (rd_line[i] !== 32'(16 + i)) begin
        fails++;
        $display("FAIL addr_change_word[%0d]: got %0d want %0d", i, rd_line[i], 16 + i);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int seen;
    int cyc;
    step();
    wr_req = 1'b1;
    addr = 10'd0;
    for (int i = 0; i < LS; i++) wr_line[i] = 32'h5500 + 32'(i);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    tests++;
    if (gnt !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_gnt: got %b want 0", gnt);
    end
    for (int i = 0; i < LS; i++) begin
      tests++;
      if (rd_line[i] !== 32'd0) begin
        fails++;
        $display("FAIL rst_mid_rd_line[%0d]: got %0h want 0", i, rd_line[i]);
      end
    end
    wr_req = 1'b0;
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (gnt === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL rst_mid_no_gnt: got %0d gnt pulses want 0", seen);
    end
    read_line(10'd0, cyc);
    tests++;
    if (cyc !== LAT) begin
      fails++;
      $display("FAIL rst_mid_read0_latency: got %0d want %0d", cyc, LAT);
    end
    for (int i = 0; i < LS; i++) begin
      tests++;
      if (rd_line[i] !== 32'(i)) begin
        fails++;
        $display("FAIL rst_mid_read0_word[%0d]: got %0h want %0h", i, rd_line[i], i);
      end
    end
  endtask

  task automatic test_simultaneous();
    int cyc;
    step();
    rd_req = 1'b1;
    wr_req = 1'b1;
    addr = 10'd4;
    for (int i = 0; i < LS; i++) wr_line[i] = 32'hFF;
    wait_gnt(0, cyc);
    rd_req = 1'b0;
    wr_req = 1'b0;
    tests++;
    if (cyc !== LAT) begin
      fails++;
      $display("FAIL simul_latency: got %0d want %0d", cyc, LAT);
    end
    for (int i = 0; i < LS; i++) begin
      tests++;
      if (rd_line[i] !== 32'(i)) begin
        fails++;
        $display("FAIL simul_rd_line_kept[%0d]: got %0h want %0h", i, rd_line[i], i);
      end
    end
    read_line(10'd4, cyc);
    tests++;
    if (cyc !== LAT) begin
      fails++;
      $display("FAIL simul_read4_latency: got %0d want %0d", cyc, LAT);
    end
    for (int i = 0; i < LS; i++) begin
      tests++;
      if (rd_line[i] !== 32'hFF) begin
        fails++;
        $display("FAIL simul_read4_word[%0d]: got %0h want ff", i, rd_line[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < LS; i++) wr_line[i] = 32'd0;
    test_reset();
    test_read();
    test_back_to_back();
    test_abort();
    test_addr_change();
    test_reset_mid_write();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
